// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared opcodes, FSM states, issue tag and mode-reachability rules for the
// ALU command sequencer.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_ABS = 3'd6;
  localparam logic [2:0] OP_PRE = 3'd7;

  localparam int RSP_W = 19;

  typedef enum logic {S_RUN, S_DETOUR} state_t;

  typedef struct packed {
    logic       keep;
    logic [2:0] op;
  } tag_t;

  // True when the ALU may switch from 'mode' straight to 'op'.
  function automatic logic reach(input logic [2:0] mode, input logic [2:0] op);
    logic r;
    r = 1'b0;
    if (op == mode) begin
      r = 1'b1;
    end else begin
      case (mode)
        OP_ADD, OP_SUB: r = (op != OP_PRE);
        OP_MUL:         r = (op == OP_ADD) || (op == OP_SUB) || (op == OP_DIV) || (op == OP_XOR);
        OP_DIV:         r = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ABS);
        OP_NOT:         r = (op == OP_SUB) || (op == OP_XOR);
        OP_XOR:         r = (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
        OP_ABS:         r = (op == OP_SUB) || (op == OP_XOR);
        default:        r = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Request, ALU-drive and response signals of the ALU command sequencer.
interface alu_cmd_sequencer_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_op_i;
  logic [7:0]  req_a_i;
  logic [7:0]  req_b_i;
  logic [7:0]  alu_a_o;
  logic [7:0]  alu_b_o;
  logic [2:0]  alu_inst_o;
  logic [15:0] alu_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [15:0] rsp_data_o;
  logic [2:0]  rsp_op_o;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, alu_data_i, rsp_ready_i,
    output req_ready_o, alu_a_o, alu_b_o, alu_inst_o, rsp_valid_o, rsp_data_o, rsp_op_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, alu_data_i, rsp_ready_i,
    input  req_ready_o, alu_a_o, alu_b_o, alu_inst_o, rsp_valid_o, rsp_data_o, rsp_op_o
  );
endinterface

// File: rtl/alu_cmd_sequencer_fifo.sv
// Response FIFO with first-word-fall-through output; push and pop may both
// happen while full.
module alu_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 19
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_pop;
  logic          w_push;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop && (r_count != '0);
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_valid = (r_count != '0);
  assign o_data  = o_valid ? r_mem[r_rd] : '0;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_pop)  r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The credit counter upstream is meant to make this impossible.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_push && w_full && !w_pop));

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issues requests to the instruction ALU, inserting a SUB detour when the mode
// change is not direct, and realigns results with their opcode.
//   state    | meaning
//   S_RUN    | accepting requests; issue direct, detour, or hold
//   S_DETOUR | SUB detour in flight; issue the pending request
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int RSP_DEPTH = 4
) (
  input logic                clk_p_i,
  input logic                reset_p_i,
  alu_cmd_sequencer_if.slave bus
);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [2:0]       r_mode;
  logic [2:0]       w_next_mode;
  logic [7:0]       r_pend_a;
  logic [7:0]       r_pend_b;
  logic [2:0]       r_pend_op;
  logic [7:0]       r_alu_a;
  logic [7:0]       r_alu_b;
  logic [2:0]       r_alu_inst;
  tag_t             r_tag0;
  tag_t             r_tag1;
  tag_t             r_tag2;
  logic [CW-1:0]    r_outst;

  logic             w_ready;
  logic             w_accept;
  logic             w_pop;
  logic             w_load_pend;
  logic [2:0]       w_target;
  logic [7:0]       w_iss_a;
  logic [7:0]       w_iss_b;
  logic [2:0]       w_iss_inst;
  tag_t             w_iss_tag;
  logic             w_fifo_valid;
  logic [RSP_W-1:0] w_fifo_data;

  assign w_ready  = !reset_p_i && (r_state == S_RUN) && (r_outst < CW'(RSP_DEPTH));
  assign w_accept = bus.req_valid_i && w_ready;
  assign w_target = (bus.req_op_i == OP_PRE) ? r_mode : bus.req_op_i;
  assign w_pop    = w_fifo_valid && bus.rsp_ready_i;

  always_comb begin
    w_next_state = r_state;
    w_next_mode  = r_mode;
    w_iss_a      = 8'd0;
    w_iss_b      = 8'd0;
    w_iss_inst   = OP_PRE;
    w_iss_tag    = '{keep: 1'b0, op: OP_PRE};
    w_load_pend  = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_accept) begin
          w_iss_a = bus.req_a_i;
          w_iss_b = bus.req_b_i;
          if (reach(r_mode, w_target)) begin
            w_iss_inst  = w_target;
            w_iss_tag   = '{keep: 1'b1, op: w_target};
            w_next_mode = w_target;
          end else begin
            // SUB reaches every mode, so one discarded detour always suffices.
            w_iss_inst   = OP_SUB;
            w_iss_tag    = '{keep: 1'b0, op: OP_SUB};
            w_next_mode  = OP_SUB;
            w_load_pend  = 1'b1;
            w_next_state = S_DETOUR;
          end
        end
      end
      S_DETOUR: begin
        w_iss_a      = r_pend_a;
        w_iss_b      = r_pend_b;
        w_iss_inst   = r_pend_op;
        w_iss_tag    = '{keep: 1'b1, op: r_pend_op};
        w_next_mode  = r_pend_op;
        w_next_state = S_RUN;
      end
      default: w_next_state = S_RUN;
    endcase
  end

  always_ff @(posedge clk_p_i or posedge reset_p_i) begin
    if (reset_p_i) begin
      r_state    <= S_RUN;
      r_mode     <= OP_ADD;
      r_pend_a   <= 8'd0;
      r_pend_b   <= 8'd0;
      r_pend_op  <= OP_ADD;
      r_alu_a    <= 8'd0;
      r_alu_b    <= 8'd0;
      r_alu_inst <= OP_PRE;
      r_tag0     <= '{keep: 1'b0, op: OP_PRE};
      r_tag1     <= '{keep: 1'b0, op: OP_PRE};
      r_tag2     <= '{keep: 1'b0, op: OP_PRE};
      r_outst    <= '0;
    end else begin
      r_state    <= w_next_state;
      r_mode     <= w_next_mode;
      if (w_load_pend) begin
        r_pend_a  <= bus.req_a_i;
        r_pend_b  <= bus.req_b_i;
        r_pend_op <= w_target;
      end
      r_alu_a    <= w_iss_a;
      r_alu_b    <= w_iss_b;
      r_alu_inst <= w_iss_inst;
      // ALU result appears two cycles after its instruction is presented.
      r_tag0     <= w_iss_tag;
      r_tag1     <= r_tag0;
      r_tag2     <= r_tag1;
      case ({w_accept, w_pop})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
    end
  end

  alu_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .W     (RSP_W)
  ) u_rsp_fifo (
    .i_clk   (clk_p_i),
    .i_rst   (reset_p_i),
    .i_push  (r_tag2.keep),
    .i_data  ({bus.alu_data_i, r_tag2.op}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_valid (w_fifo_valid)
  );

  assign bus.req_ready_o = w_ready;
  assign bus.alu_a_o     = r_alu_a;
  assign bus.alu_b_o     = r_alu_b;
  assign bus.alu_inst_o  = r_alu_inst;
  assign bus.rsp_valid_o = w_fifo_valid;
  assign bus.rsp_data_o  = w_fifo_data[RSP_W-1:3];
  assign bus.rsp_op_o    = w_fifo_data[2:0];

endmodule
